sdr_stream_ctrl: RTL and testbench

SDR_STREAM_CTRL -- requirements
Module: sdr_stream_ctrl

---
 rtl/sdr_stream_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sdr_stream_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_stream_ctrl.sv
// SDR bridge stream controller: moves up to one bridge line between the SDR bridge and a
// word-wide valid/ready stream, with argument checking and a bridge-handshake timeout.
module sdr_stream_ctrl #(
   parameter int unsigned LINE_W  = 2048,
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned NELEM_W = 30,
   parameter int unsigned TMO_W   = 16
) (
   input  logic               sdr_clk,
   input  logic               sdr_reset,

   input  logic               start,
   input  logic               mode,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [NELEM_W-1:0] nelems,
   output logic               busy,
   output logic               done,
   output logic               error,

   output logic [ADDR_W-1:0]  sdr_baseaddr,
   output logic [NELEM_W-1:0] sdr_nelems,
   output logic               sdr_readstart,
   input  logic               sdr_readend,
   input  logic [LINE_W-1:0]  sdr_readdata,
   output logic               sdr_writestart,
   input  logic               sdr_writeend,
   output logic [LINE_W-1:0]  sdr_writedata,

   output logic               out_valid,
   input  logic               out_ready,
   output logic [WORD_W-1:0]  out_data,
   output logic               out_last,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WORD_W-1:0]  in_data
);

   localparam int unsigned NW    = LINE_W / WORD_W;
   localparam int unsigned IDX_W = (NW > 1) ? $clog2(NW) : 1;
   // Leaving the wait state on this value means the counter itself lands on all-ones.
   localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

   if ((LINE_W % WORD_W) != 0 || NW == 0) begin : g_bad_line_w
      $error("LINE_W must be a non-zero integer multiple of WORD_W");
   end

   typedef enum logic [2:0] {
      StIdle, StRdReq, StRdWait, StRdStream, StWrFill, StWrReq, StWrWait, StFin
   } state_e;

   state_e                          state_q, state_d;
   logic [NW-1:0][WORD_W-1:0]       line_q, line_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [TMO_W-1:0]                tmo_q, tmo_d;
   logic [ADDR_W-1:0]               base_q, base_d;
   logic [NELEM_W-1:0]              nelems_q, nelems_d;
   logic                            err_q, err_d;

   logic nelems_bad;
   logic idx_is_last;

   assign nelems_bad  = (nelems == '0) || (32'(nelems) > NW);
   assign idx_is_last = (NELEM_W'(idx_q) == (nelems_q - NELEM_W'(1)));

   always_ff @(posedge sdr_clk or posedge sdr_reset) begin
      if (sdr_reset) begin
         state_q  <= StIdle;
         line_q   <= '0;
         idx_q    <= '0;
         tmo_q    <= '0;
         base_q   <= '0;
         nelems_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         line_q   <= line_d;
         idx_q    <= idx_d;
         tmo_q    <= tmo_d;
         base_q   <= base_d;
         nelems_q <= nelems_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      line_d   = line_q;
      idx_d    = idx_q;
      tmo_d    = tmo_q;
      base_d   = base_q;
      nelems_d = nelems_q;
      err_d    = err_q;
      unique case (state_q)
         StIdle: begin
            err_d = 1'b0;
            idx_d = '0;
            tmo_d = '0;
            if (start) begin
               base_d   = base_addr;
               nelems_d = nelems;
               if (nelems_bad) begin
                  err_d   = 1'b1;
                  state_d = StFin;
               end else if (mode) begin
                  line_d  = '0;
                  state_d = StWrFill;
               end else begin
                  state_d = StRdReq;
               end
            end
         end
         StRdReq: begin
            tmo_d   = '0;
            state_d = StRdWait;
         end
         StRdWait: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (sdr_readend) begin
               line_d  = sdr_readdata;
               idx_d   = '0;
               state_d = StRdStream;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = StFin;
            end
         end
         StRdStream: begin
            if (out_ready) begin
               if (idx_is_last) state_d = StFin;
               else             idx_d   = idx_q + IDX_W'(1);
            end
         end
         StWrFill: begin
            if (in_valid) begin
               line_d[idx_q] = in_data;
               if (idx_is_last) state_d = StWrReq;
               else             idx_d   = idx_q + IDX_W'(1);
            end
         end
         StWrReq: begin
            tmo_d   = '0;
            state_d = StWrWait;
         end
         StWrWait: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (sdr_writeend) begin
               state_d = StFin;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = StFin;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy           = (state_q != StIdle);
      done           = (state_q == StFin);
      error          = (state_q == StFin) && err_q;
      sdr_baseaddr   = '0;
      sdr_nelems     = '0;
      sdr_readstart  = (state_q == StRdReq);
      sdr_writestart = (state_q == StWrReq);
      sdr_writedata  = '0;
      out_valid      = 1'b0;
      out_data       = '0;
      out_last       = 1'b0;
      in_ready       = (state_q == StWrFill);
      if (state_q inside {StRdReq, StRdWait, StWrReq, StWrWait}) begin
         sdr_baseaddr = base_q;
         sdr_nelems   = nelems_q;
      end
      if (state_q inside {StWrReq, StWrWait}) begin
         sdr_writedata = line_q;
      end
      if (state_q == StRdStream) begin
         out_valid = 1'b1;
         out_data  = line_q[idx_q];
         out_last  = idx_is_last;
      end
   end

endmodule

// File: tb/tb_sdr_stream_ctrl.sv
// Randomized bench for sdr_stream_ctrl; expected beats and lines come from word queues.
module tb_sdr_stream_ctrl;

   localparam int unsigned LINE_W  = 256;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned NELEM_W = 30;
   localparam int unsigned TMO_W   = 4;
   localparam int unsigned NW      = LINE_W / WORD_W;

   logic               sdr_clk = 1'b0;
   logic               sdr_reset = 1'b1;
   logic               start = 1'b0, mode = 1'b0;
   logic [ADDR_W-1:0]  base_addr = '0;
   logic [NELEM_W-1:0] nelems = '0;
   logic               busy, done, error;
   logic [ADDR_W-1:0]  sdr_baseaddr;
   logic [NELEM_W-1:0] sdr_nelems;
   logic               sdr_readstart, sdr_writestart;
   logic               sdr_readend = 1'b0, sdr_writeend = 1'b0;
   logic [LINE_W-1:0]  sdr_readdata = '0;
   logic [LINE_W-1:0]  sdr_writedata;
   logic               out_valid, out_last, in_ready;
   logic               out_ready = 1'b0, in_valid = 1'b0;
   logic [WORD_W-1:0]  out_data;
   logic [WORD_W-1:0]  in_data = '0;

   int checks = 0;
   int errors = 0;

   sdr_stream_ctrl #(
      .LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .NELEM_W(NELEM_W), .TMO_W(TMO_W)
   ) dut (
      .sdr_clk(sdr_clk), .sdr_reset(sdr_reset),
      .start(start), .mode(mode), .base_addr(base_addr), .nelems(nelems),
      .busy(busy), .done(done), .error(error),
      .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems),
      .sdr_readstart(sdr_readstart), .sdr_readend(sdr_readend), .sdr_readdata(sdr_readdata),
      .sdr_writestart(sdr_writestart), .sdr_writeend(sdr_writeend),
      .sdr_writedata(sdr_writedata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
   );

   always #5 sdr_clk = ~sdr_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge sdr_clk);
      #1;
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < int'(NW); i++) l[i*WORD_W +: WORD_W] = $urandom;
      return l;
   endfunction

   task automatic test_reset();
      sdr_reset = 1'b1;
      step();
      step();
      checks++;
      if ({busy, done, error, sdr_readstart, sdr_writestart, out_valid, out_last, in_ready}
          !== 8'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 00000000", {busy, done, error, sdr_readstart,
                  sdr_writestart, out_valid, out_last, in_ready});
      end
      checks++;
      if (sdr_baseaddr !== '0 || sdr_nelems !== '0 || out_data !== '0 || sdr_writedata !== '0)
      begin
         errors++;
         $display("FAIL reset_data: got addr=%h nel=%h out=%h wd!=0:%b want all zero",
                  sdr_baseaddr, sdr_nelems, out_data, sdr_writedata != '0);
      end
      sdr_reset = 1'b0;
      step();
   endtask

   task automatic run_read(input int n, input logic [LINE_W-1:0] line, input bit stall,
                           input string tag);
      logic [WORD_W-1:0] exp_q[$];
      logic [ADDR_W-1:0] base;
      logic [WORD_W-1:0] prev;
      bit                prev_stalled;
      int                wait_cyc, cyc, beats;
      for (int i = 0; i < n; i++) exp_q.push_back(line[i*WORD_W +: WORD_W]);
      base      = $urandom;
      start     = 1'b1;
      mode      = 1'b0;
      base_addr = base;
      nelems    = NELEM_W'(n);
      step();
      start = 1'b0;
      checks++;
      if (sdr_readstart !== 1'b1 || sdr_baseaddr !== base || sdr_nelems !== NELEM_W'(n)) begin
         errors++;
         $display("FAIL %s rd_req: got rs=%b addr=%h nel=%0d want rs=1 addr=%h nel=%0d", tag,
                  sdr_readstart, sdr_baseaddr, sdr_nelems, base, n);
      end
      step();
      wait_cyc = $urandom_range(0, 3);
      for (int i = 0; i <= wait_cyc; i++) begin
         checks++;
         if (sdr_readstart !== 1'b0 || out_valid !== 1'b0 || sdr_baseaddr !== base) begin
            errors++;
            $display("FAIL %s rd_wait: got rs=%b ov=%b addr=%h want rs=0 ov=0 addr=%h", tag,
                     sdr_readstart, out_valid, sdr_baseaddr, base);
         end
         if (i == wait_cyc) begin
            sdr_readend  = 1'b1;
            sdr_readdata = line;
         end
         step();
      end
      sdr_readend  = 1'b0;
      sdr_readdata = ~line;
      checks++;
      if (out_valid !== 1'b1 || sdr_baseaddr !== '0) begin
         errors++;
         $display("FAIL %s rd_latency: got ov=%b addr=%h want ov=1 addr=0", tag, out_valid,
                  sdr_baseaddr);
      end
      beats = 0;
      cyc = 0;
      prev_stalled = 1'b0;
      prev = '0;
      while (beats < n && cyc < 4 * int'(NW) + 8) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_q[0] || out_last !== (exp_q.size() == 1))
         begin
            errors++;
            $display("FAIL %s beat%0d: got ov=%b d=%h last=%b want ov=1 d=%h last=%b", tag,
                     beats, out_valid, out_data, out_last, exp_q[0], exp_q.size() == 1);
         end
         if (prev_stalled) begin
            checks++;
            if (out_data !== prev) begin
               errors++;
               $display("FAIL %s stall_stable: got %h want %h", tag, out_data, prev);
            end
         end
         out_ready   = stall ? ((cyc % 2) == 0) : 1'b1;
         sdr_readend = $urandom_range(0, 1);
         prev = out_data;
         prev_stalled = !out_ready;
         step();
         if (out_ready) begin
            void'(exp_q.pop_front());
            beats++;
         end
         cyc++;
      end
      out_ready   = 1'b0;
      sdr_readend = 1'b0;
      checks++;
      if (beats != n) begin
         errors++;
         $display("FAIL %s beat_count: got %0d want %0d", tag, beats, n);
      end
      checks++;
      if (done !== 1'b1 || error !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s rd_done: got done=%b err=%b ov=%b want 1 0 0", tag, done, error,
                  out_valid);
      end
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s rd_idle: got busy=%b done=%b want 0 0", tag, busy, done);
      end
   endtask

   task automatic run_write(input logic [WORD_W-1:0] words[$], input string tag);
      logic [LINE_W-1:0] exp_line;
      logic [ADDR_W-1:0] base;
      int                n, sent, cyc, wait_cyc;
      n = words.size();
      exp_line = '0;
      for (int i = 0; i < n; i++) exp_line[i*WORD_W +: WORD_W] = words[i];
      base      = $urandom;
      start     = 1'b1;
      mode      = 1'b1;
      base_addr = base;
      nelems    = NELEM_W'(n);
      step();
      start = 1'b0;
      sent = 0;
      cyc = 0;
      while (sent < n && cyc < 100) begin
         checks++;
         if (in_ready !== 1'b1 || sdr_writestart !== 1'b0 || out_valid !== 1'b0 ||
             sdr_baseaddr !== '0) begin
            errors++;
            $display("FAIL %s wr_fill: got ir=%b ws=%b ov=%b addr=%h want 1 0 0 0", tag,
                     in_ready, sdr_writestart, out_valid, sdr_baseaddr);
         end
         in_valid     = ($urandom_range(0, 2) != 0);
         in_data      = in_valid ? words[sent] : WORD_W'($urandom);
         sdr_writeend = ($urandom_range(0, 3) == 0);
         start        = ($urandom_range(0, 3) == 0);
         mode         = $urandom_range(0, 1);
         step();
         if (in_valid) sent++;
         cyc++;
      end
      in_valid     = 1'b0;
      sdr_writeend = 1'b0;
      start        = 1'b0;
      checks++;
      if (sdr_writestart !== 1'b1 || sdr_writedata !== exp_line || sdr_baseaddr !== base ||
          in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s wr_req: got ws=%b wd=%h addr=%h ir=%b want ws=1 wd=%h addr=%h ir=0",
                  tag, sdr_writestart, sdr_writedata, sdr_baseaddr, in_ready, exp_line, base);
      end
      step();
      wait_cyc = $urandom_range(0, 4);
      for (int i = 0; i <= wait_cyc; i++) begin
         checks++;
         if (sdr_writestart !== 1'b0 || sdr_writedata !== exp_line || done !== 1'b0) begin
            errors++;
            $display("FAIL %s wr_wait: got ws=%b wd=%h done=%b want ws=0 wd=%h done=0", tag,
                     sdr_writestart, sdr_writedata, done, exp_line);
         end
         if (i == wait_cyc) sdr_writeend = 1'b1;
         step();
      end
      sdr_writeend = 1'b0;
      checks++;
      if (done !== 1'b1 || error !== 1'b0 || sdr_writestart !== 1'b0) begin
         errors++;
         $display("FAIL %s wr_done: got done=%b err=%b ws=%b want 1 0 0", tag, done, error,
                  sdr_writestart);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s wr_idle: got busy=%b want 0", tag, busy);
      end
   endtask

   task automatic test_read_basic();
      logic [LINE_W-1:0] l;
      l = rand_line();
      l[31:0]  = 32'h11111111;
      l[63:32] = 32'h22222222;
      l[95:64] = 32'h33333333;
      run_read(3, l, 1'b0, "read_basic");
      run_read(3, l, 1'b1, "read_stall");
   endtask

   task automatic test_read_random();
      for (int t = 0; t < 5; t++) begin
         run_read(int'($urandom_range(1, NW)), rand_line(), 1'($urandom_range(0, 1)),
                  "read_rand");
      end
      run_read(int'(NW), rand_line(), 1'b1, "read_full");
   endtask

   task automatic test_write();
      logic [WORD_W-1:0] w[$];
      int                n;
      run_read(int'(NW), rand_line(), 1'b0, "read_dirty");
      w = {32'hDEADBEEF, 32'hBEEFD00D};
      run_write(w, "write_basic");
      checks++;
      if (w[1] != 32'hBEEFD00D) begin
         errors++;
         $display("FAIL write_basic_words: got %h want beefd00d", w[1]);
      end
      for (int t = 0; t < 4; t++) begin
         w.delete();
         n = (t == 3) ? int'(NW) : int'($urandom_range(1, NW));
         for (int i = 0; i < n; i++) w.push_back(WORD_W'($urandom));
         run_write(w, "write_rand");
      end
   endtask

   task automatic test_bad_nelems();
      int done_at, ndone, pulses;
      for (int c = 0; c < 2; c++) begin
         start  = 1'b1;
         mode   = 1'(c);
         nelems = (c == 0) ? NELEM_W'(0) : NELEM_W'(NW + 1);
         step();
         start = 1'b0;
         done_at = -1;
         ndone = 0;
         pulses = 0;
         for (int k = 1; k <= 4; k++) begin
            if (done === 1'b1) begin
               if (done_at < 0) done_at = k;
               ndone++;
               checks++;
               if (error !== 1'b1) begin
                  errors++;
                  $display("FAIL bad_nelems%0d error: got %b want 1", c, error);
               end
            end
            if (sdr_readstart !== 1'b0 || sdr_writestart !== 1'b0) pulses++;
            step();
         end
         checks++;
         if (done_at < 1 || done_at > 2 || ndone != 1 || pulses != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_nelems%0d: got done_at=%0d ndone=%0d pulses=%0d busy=%b want %s",
                     c, done_at, ndone, pulses, busy, "done_at 1..2 ndone=1 pulses=0 busy=0");
         end
      end
   endtask

   task automatic test_timeout();
      int cyc, pulses;
      start     = 1'b1;
      mode      = 1'b0;
      base_addr = $urandom;
      nelems    = NELEM_W'(1);
      step();
      start = 1'b0;
      step();
      cyc = 0;
      pulses = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (sdr_readstart !== 1'b0) pulses++;
         cyc++;
         step();
      end
      checks++;
      if (cyc != (1 << TMO_W) - 1 || error !== 1'b1 || pulses != 0) begin
         errors++;
         $display("FAIL timeout: got wait=%0d err=%b pulses=%0d want wait=%0d err=1 pulses=0",
                  cyc, error, pulses, (1 << TMO_W) - 1);
      end
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_reset_midstream();
      logic [LINE_W-1:0] l;
      int                ndone;
      l = rand_line();
      start  = 1'b1;
      mode   = 1'b0;
      nelems = NELEM_W'(4);
      step();
      start = 1'b0;
      step();
      sdr_readend  = 1'b1;
      sdr_readdata = l;
      step();
      sdr_readend = 1'b0;
      out_ready   = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== l[63:32]) begin
         errors++;
         $display("FAIL midreset_beat2: got ov=%b d=%h want ov=1 d=%h", out_valid, out_data,
                  l[63:32]);
      end
      #2;
      sdr_reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, error, out_valid, out_last, in_ready, sdr_readstart, sdr_writestart}
          !== 8'b0 || out_data !== '0 || sdr_baseaddr !== '0 || sdr_nelems !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got ctl=%b d=%h addr=%h nel=%h want all zero",
                  {busy, done, error, out_valid, out_last, in_ready, sdr_readstart,
                   sdr_writestart}, out_data, sdr_baseaddr, sdr_nelems);
      end
      ndone = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (done !== 1'b0) ndone++;
      end
      sdr_reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         if (done !== 1'b0) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL midreset_nodone: got %0d done cycles want 0", ndone);
      end
      run_read(1, rand_line(), 1'b0, "read_after_reset");
   endtask

   initial begin
      test_reset();
      test_read_basic();
      test_read_random();
      test_write();
      test_bad_nelems();
      test_timeout();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
